// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encoding, start-op helpers and the FSM state type.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mdu_start(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mdu_mult(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core; result is staged by e_mdu and
// committed once the modelled latency has elapsed.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] sprod;
  logic        [2*WIDTH-1:0] uprod;
  logic                      bzero, ovf;
  logic        [WIDTH-1:0]   bs_div, bu_div, uq, ur;
  logic signed [WIDTH-1:0]   sq, sr;

  assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Dividing by 1 instead of 0 or -1 keeps the divider defined; for the
  // most-negative/-1 overflow it also yields exactly LO=a, HI=0.
  assign bzero  = (b == '0);
  assign ovf    = (a == MOST_NEG) && (b == '1);
  assign bs_div = (bzero || ovf) ? WIDTH'(1) : b;
  assign bu_div = bzero ? WIDTH'(1) : b;

  assign sq = $signed(a) / $signed(bs_div);
  assign sr = $signed(a) % $signed(bs_div);
  assign uq = a / bu_div;
  assign ur = a % bu_div;

  always_comb begin
    hi          = '0;
    lo          = '0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT:  {hi, lo} = sprod;
      MDU_MULTU: {hi, lo} = uprod;
      MDU_DIV: begin
        lo          = sq;
        hi          = sr;
        div_by_zero = bzero;
      end
      MDU_DIVU: begin
        lo          = uq;
        hi          = ur;
        div_by_zero = bzero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: multi-cycle mult/div with staged commit into HI/LO,
// plus mfhi/mflo/mthi/mtlo and a busy/stall indication for hazard logic.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mdu_op,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_r, lo_r, stg_hi, stg_lo;
  logic             stg_dbz;
  logic [WIDTH-1:0] ar_hi, ar_lo;
  logic             ar_dbz;
  logic             launch, done;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op          (mdu_op),
    .a           (src_a),
    .b           (src_b),
    .hi          (ar_hi),
    .lo          (ar_lo),
    .div_by_zero (ar_dbz)
  );

  assign launch = (state_q == IDLE) && start && is_mdu_start(mdu_op);
  assign done   = (state_q == RUN) && (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      stg_hi  <= '0;
      stg_lo  <= '0;
      stg_dbz <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        stg_hi  <= ar_hi;
        stg_lo  <= ar_lo;
        stg_dbz <= ar_dbz;
        cnt_q   <= is_mdu_mult(mdu_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - CW'(1);
        // divide-by-zero still burns the full latency but leaves HI/LO alone
        if (done && !stg_dbz) begin
          hi_r <= stg_hi;
          lo_r <= stg_lo;
        end
      end else if (!start) begin
        if (mdu_op == MDU_MTHI)      hi_r <= src_a;
        else if (mdu_op == MDU_MTLO) lo_r <= src_a;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (mdu_op == MDU_MFHI)      rd_data = hi_r;
    else if (mdu_op == MDU_MFLO) rd_data = lo_r;
  end

  assign busy      = (state_q == RUN);
  assign stall_req = busy | start;
  assign hi_q      = hi_r;
  assign lo_q      = lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed spec cases plus randomized ops
// checked against a 64-bit arithmetic reference model of HI/LO.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a, src_b;
  logic [31:0] rd_data, hi_q, lo_q;
  logic        busy, stall_req;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdu_op    (mdu_op),
    .start     (start),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_data   (rd_data),
    .busy      (busy),
    .stall_req (stall_req),
    .hi_q      (hi_q),
    .lo_q      (lo_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-precision arithmetic, HI/LO taken from the 64-bit result.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 32'h0) begin q = sa / sb; r = sa - q * sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 32'h0) begin q = ua / ub; r = ua - q * ub; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input string tag);
    int n;
    mdu_op = op; src_a = a; src_b = b; start = 1'b1;
    #1;
    ntests++;
    if (stall_req !== 1'b1) begin nfail++; $display("FAIL %s stall_on_start got %b want 1", tag, stall_req); end
    tick();
    start = 1'b0; mdu_op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      ntests++;
      if (stall_req !== 1'b1) begin nfail++; $display("FAIL %s stall_busy got %b want 1", tag, stall_req); end
      n++;
      tick();
    end
    ntests++;
    if (n != cyc) begin nfail++; $display("FAIL %s busy_cycles got %0d want %0d", tag, n, cyc); end
    model(op, a, b);
    ntests++;
    if (hi_q !== m_hi) begin nfail++; $display("FAIL %s hi got %h want %h", tag, hi_q, m_hi); end
    ntests++;
    if (lo_q !== m_lo) begin nfail++; $display("FAIL %s lo got %h want %h", tag, lo_q, m_lo); end
    mdu_op = 4'd5; #1;
    ntests++;
    if (rd_data !== m_hi) begin nfail++; $display("FAIL %s mfhi got %h want %h", tag, rd_data, m_hi); end
    mdu_op = 4'd6; #1;
    ntests++;
    if (rd_data !== m_lo) begin nfail++; $display("FAIL %s mflo got %h want %h", tag, rd_data, m_lo); end
    mdu_op = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    mdu_op = op; src_a = v; start = 1'b0;
    tick();
    mdu_op = 4'd0;
    if (op == 4'd7) m_hi = v; else m_lo = v;
    ntests++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      nfail++; $display("FAIL mt%0d hi/lo got %h/%h want %h/%h", op, hi_q, lo_q, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; src_a = '0; src_b = '0;
    repeat (2) tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    ntests++;
    if (busy !== 1'b0 || stall_req !== 1'b0) begin nfail++; $display("FAIL reset busy/stall got %b/%b want 0/0", busy, stall_req); end
    ntests++;
    if (hi_q !== 32'h0 || lo_q !== 32'h0) begin nfail++; $display("FAIL reset hi/lo got %h/%h want 0/0", hi_q, lo_q); end
  endtask

  task automatic test_mult();
    run_op(4'd1, 32'hFFFFFFFE, 32'h3, 5, "mult");
    ntests++;
    if (hi_q !== 32'hFFFFFFFF || lo_q !== 32'hFFFFFFFA) begin
      nfail++; $display("FAIL mult_lit got %h/%h want ffffffff/fffffffa", hi_q, lo_q);
    end
    run_op(4'd2, 32'hFFFFFFFF, 32'h2, 5, "multu");
    ntests++;
    if (hi_q !== 32'h1 || lo_q !== 32'hFFFFFFFE) begin
      nfail++; $display("FAIL multu_lit got %h/%h want 00000001/fffffffe", hi_q, lo_q);
    end
  endtask

  task automatic test_div();
    run_op(4'd3, 32'hFFFFFFF9, 32'h2, 10, "div");
    ntests++;
    if (hi_q !== 32'hFFFFFFFF || lo_q !== 32'hFFFFFFFD) begin
      nfail++; $display("FAIL div_lit got %h/%h want ffffffff/fffffffd", hi_q, lo_q);
    end
    mt(4'd7, 32'h12);
    mt(4'd8, 32'h34);
    run_op(4'd4, 32'h7, 32'h0, 10, "divu_by0");
    ntests++;
    if (hi_q !== 32'h12 || lo_q !== 32'h34) begin
      nfail++; $display("FAIL divz_lit got %h/%h want 00000012/00000034", hi_q, lo_q);
    end
  endtask

  task automatic test_overflow();
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
    ntests++;
    if (hi_q !== 32'h0 || lo_q !== 32'h80000000) begin
      nfail++; $display("FAIL ovf_lit got %h/%h want 00000000/80000000", hi_q, lo_q);
    end
  endtask

  task automatic test_nop();
    for (int op = 9; op < 16; op++) begin
      mdu_op = 4'(op); src_a = $urandom; src_b = $urandom; start = 1'b1;
      #1;
      ntests++;
      if (rd_data !== 32'h0) begin nfail++; $display("FAIL nop%0d rd_data got %h want 0", op, rd_data); end
      tick();
      start = 1'b0;
      ntests++;
      if (busy !== 1'b0 || hi_q !== m_hi || lo_q !== m_lo) begin
        nfail++; $display("FAIL nop%0d busy/hi/lo got %b/%h/%h want 0/%h/%h", op, busy, hi_q, lo_q, m_hi, m_lo);
      end
    end
    mdu_op = 4'd0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int n;
    a = $urandom; b = $urandom_range(1, 1000);
    mdu_op = 4'd3; src_a = a; src_b = b; start = 1'b1;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      start = 1'b0; mdu_op = 4'd0;
      if (n == 2) begin start = 1'b1; mdu_op = 4'd1; src_a = $urandom; src_b = $urandom; end
      if (n == 3) begin mdu_op = 4'd8; src_a = 32'hDEADBEEF; end
      #1;
      ntests++;
      if (stall_req !== 1'b1) begin nfail++; $display("FAIL b2b stall cycle %0d got %b want 1", n, stall_req); end
      n++;
      tick();
    end
    start = 1'b0; mdu_op = 4'd0;
    ntests++;
    if (n != 10) begin nfail++; $display("FAIL b2b busy_cycles got %0d want 10", n); end
    model(4'd3, a, b);
    ntests++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      nfail++; $display("FAIL b2b hi/lo got %h/%h want %h/%h", hi_q, lo_q, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_abort();
    mdu_op = 4'd1; src_a = 32'h5; src_b = 32'h7; start = 1'b1;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    tick();
    tick();
    ntests++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL abort pre_busy got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    ntests++;
    if (busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
      nfail++; $display("FAIL abort busy/hi/lo got %b/%h/%h want 0/0/0", busy, hi_q, lo_q);
    end
    repeat (8) tick();
    ntests++;
    if (busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
      nfail++; $display("FAIL abort_late busy/hi/lo got %b/%h/%h want 0/0/0", busy, hi_q, lo_q);
    end
    mt(4'd7, 32'hA5A5A5A5);
    mdu_op = 4'd5; #1;
    ntests++;
    if (rd_data !== 32'hA5A5A5A5) begin nfail++; $display("FAIL mthi_mfhi got %h want a5a5a5a5", rd_data); end
    mdu_op = 4'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int r;
      logic [3:0]  op;
      logic [31:0] a, b;
      r = $urandom_range(0, 5);
      a = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = $urandom_range(1, 20);
      if (r < 4) begin
        op = 4'(r + 1);
        run_op(op, a, b, (op <= 4'd2) ? 5 : 10, "rand");
      end else begin
        mt((r == 4) ? 4'd7 : 4'd8, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_overflow();
    test_nop();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
